// File: rtl/logicnets_seq_pkg.sv
// Shared types and constants for the LogicNets layer sequencer.
// Holds the FSM state encoding, the LUT fan-in and the config slot type.
package logicnets_seq_pkg;

    localparam int unsigned FANIN  = 6;
    localparam int unsigned SLOT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/fanin_gather.sv
// Combinational FANIN-way bit select: o_bits[s] = i_vec[i_row[s]].
module fanin_gather
    import logicnets_seq_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 64,
    parameter int unsigned IDX_W    = 6
) (
    input  logic [IN_WIDTH-1:0]         i_vec,
    input  logic [FANIN-1:0][IDX_W-1:0] i_row,
    output logic [FANIN-1:0]            o_bits
);

    always_comb begin
        o_bits = '0;
        for (int s = 0; s < FANIN; s++) begin
            o_bits[s] = i_vec[i_row[s]];
        end
    end

endmodule

// File: rtl/logicnets_layer_sequencer.sv
// Time-multiplexed LogicNets layer: walks one neuron per cycle through an
// external LUT bank using a programmable fan-in table, then holds the result vector.
module logicnets_layer_sequencer
    import logicnets_seq_pkg::*;
#(
    parameter  int unsigned IN_WIDTH    = 64,
    parameter  int unsigned NUM_NEURONS = 128,
    localparam int unsigned IDX_W       = $clog2(IN_WIDTH),
    localparam int unsigned NID_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [NID_W-1:0]       cfg_neuron,
    input  logic [SLOT_W-1:0]      cfg_slot,
    input  logic [IDX_W-1:0]       cfg_idx,
    output logic                   cfg_ready,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IN_WIDTH-1:0]    s_data,
    output logic [NID_W-1:0]       lut_sel,
    output logic [FANIN-1:0]       lut_in,
    input  logic                   lut_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [NUM_NEURONS-1:0] m_data,
    output logic                   busy
);

    typedef logic [IDX_W-1:0] fanin_idx_t;

    seq_state_t               r_state;
    seq_state_t               w_state_nxt;
    logic [IN_WIDTH-1:0]      r_in;
    logic [NID_W-1:0]         r_cnt;
    fanin_idx_t               r_tbl [NUM_NEURONS][FANIN];
    logic                     r_s_ready;
    logic                     r_m_valid;
    logic                     r_busy;
    logic [NUM_NEURONS-1:0]   r_m_data;
    logic [NID_W-1:0]         r_lut_sel;
    logic [FANIN-1:0]         r_lut_in;

    logic                     w_accept;
    logic                     w_last;
    logic                     w_lut_ld;
    logic                     w_cfg_ok;
    logic [NID_W-1:0]         w_cnt_nxt;
    logic [NID_W-1:0]         w_gnid;
    logic [IN_WIDTH-1:0]      w_gsrc;
    logic [FANIN-1:0][IDX_W-1:0] w_grow;
    logic [FANIN-1:0]         w_gbits;

    assign cfg_ready = (r_state == IDLE) && !s_valid;
    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign busy      = r_busy;
    assign lut_sel   = r_lut_sel;
    assign lut_in    = r_lut_in;

    // Explicit terminal compare so non-power-of-2 layers never overrun the counter.
    assign w_last   = (32'(r_cnt) == NUM_NEURONS - 1);
    assign w_cfg_ok = cfg_we && cfg_ready
                      && (32'(cfg_slot)   < FANIN)
                      && (32'(cfg_neuron) < NUM_NEURONS)
                      && (32'(cfg_idx)    < IN_WIDTH);

    // Next state; also selects which neuron's LUT address is registered next.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_lut_ld    = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_gnid      = '0;
        w_gsrc      = r_in;
        case (r_state)
            IDLE: begin
                w_gsrc = s_data;
                if (s_valid) begin
                    w_accept    = 1'b1;
                    w_lut_ld    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (w_last) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + NID_W'(1);
                    w_gnid    = w_cnt_nxt;
                    w_lut_ld  = 1'b1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_grow = '0;
        for (int s = 0; s < FANIN; s++) begin
            w_grow[s] = r_tbl[w_gnid][s];
        end
    end

    fanin_gather #(
        .IN_WIDTH (IN_WIDTH),
        .IDX_W    (IDX_W)
    ) u_gather (
        .i_vec  (w_gsrc),
        .i_row  (w_grow),
        .o_bits (w_gbits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in      <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_m_data  <= '0;
            r_lut_sel <= '0;
            r_lut_in  <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                for (int s = 0; s < FANIN; s++) begin
                    r_tbl[n][s] <= '0;
                end
            end
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_s_ready <= (w_state_nxt == IDLE);
            r_m_valid <= (w_state_nxt == HOLD);
            r_busy    <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_in <= s_data;
            end
            if (w_lut_ld) begin
                r_lut_sel <= w_gnid;
                r_lut_in  <= w_gbits;
            end
            if (r_state == EVAL) begin
                r_m_data[r_cnt] <= lut_out;
            end
            if (w_cfg_ok) begin
                r_tbl[cfg_neuron][cfg_slot] <= cfg_idx;
            end
        end
    end

endmodule

// File: tb/tb_logicnets_layer_sequencer.sv
// Directed bench for logicnets_layer_sequencer (8-bit input, 4 neurons) with a
// two-input NAND LUT model: lut_out = !(lut_in[2] & lut_in[1]).
module tb_logicnets_layer_sequencer;

    localparam int unsigned IN_WIDTH    = 8;
    localparam int unsigned NUM_NEURONS = 4;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned NID_W       = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   cfg_we;
    logic [NID_W-1:0]       cfg_neuron;
    logic [2:0]             cfg_slot;
    logic [IDX_W-1:0]       cfg_idx;
    logic                   cfg_ready;
    logic                   s_valid;
    logic                   s_ready;
    logic [IN_WIDTH-1:0]    s_data;
    logic [NID_W-1:0]       lut_sel;
    logic [5:0]             lut_in;
    logic                   lut_out;
    logic                   m_valid;
    logic                   m_ready;
    logic [NUM_NEURONS-1:0] m_data;
    logic                   busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign lut_out = !(lut_in[2] & lut_in[1]);

    logicnets_layer_sequencer #(
        .IN_WIDTH    (IN_WIDTH),
        .NUM_NEURONS (NUM_NEURONS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_slot   (cfg_slot),
        .cfg_idx    (cfg_idx),
        .cfg_ready  (cfg_ready),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .lut_sel    (lut_sel),
        .lut_in     (lut_in),
        .lut_out    (lut_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int n, input int s, input int idx);
        cfg_we     = 1'b1;
        cfg_neuron = NID_W'(n);
        cfg_slot   = 3'(s);
        cfg_idx    = IDX_W'(idx);
        tick();
        cfg_we     = 1'b0;
    endtask

    // Accept v from IDLE, check result at cycle A+5, complete the handshake.
    task automatic run_vec(input logic [7:0] v, input string tag, input logic [3:0] exp);
        s_valid = 1'b1;
        s_data  = v;
        m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        repeat (NUM_NEURONS) tick();
        chk({tag, "_m_valid"}, 64'(m_valid), 64'(1));
        chk({tag, "_m_data"},  64'(m_data),  64'(exp));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        int  first_acc;
        int  second_acc;
        int  n_acc;
        int  n_hs;
        logic acc;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_neuron = '0; cfg_slot = '0; cfg_idx = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: reset asserted while idle
        rst_n = 1'b0;
        #1;
        chk("t1_s_ready", 64'(s_ready), 64'(1));
        chk("t1_m_valid", 64'(m_valid), 64'(0));
        chk("t1_busy",    64'(busy),    64'(0));
        chk("t1_lut_sel", 64'(lut_sel), 64'(0));
        chk("t1_lut_in",  64'(lut_in),  64'(0));
        chk("t1_m_data",  64'(m_data),  64'(0));
        #2;
        rst_n = 1'b1;
        tick();
        chk("t1_cfg_ready", 64'(cfg_ready), 64'(1));

        // 2: basic gather and result
        for (int s = 0; s < 6; s++) cfg(0, s, s);
        for (int s = 0; s < 6; s++) cfg(1, s, s + 2);
        s_valid = 1'b1;
        s_data  = 8'b0000_0110;
        tick();
        s_valid = 1'b0;
        chk("t2_sel0",   64'(lut_sel), 64'(0));
        chk("t2_in0",    64'(lut_in),  64'(6'b000110));
        chk("t2_busy",   64'(busy),    64'(1));
        chk("t2_sready", 64'(s_ready), 64'(0));
        tick();
        chk("t2_sel1",   64'(lut_sel), 64'(1));
        chk("t2_in1",    64'(lut_in),  64'(6'b000001));
        tick();
        tick();
        chk("t2_mvalid_a4", 64'(m_valid), 64'(0));
        tick();
        chk("t2_mvalid_a5", 64'(m_valid), 64'(1));
        chk("t2_m_data",    64'(m_data),  64'(4'b1110));

        // 3: backpressure in HOLD
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t3_m_valid", 64'(m_valid), 64'(1));
            chk("t3_m_data",  64'(m_data),  64'(4'b1110));
        end
        chk("t3_s_ready",   64'(s_ready),   64'(0));
        chk("t3_cfg_ready", 64'(cfg_ready), 64'(0));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("t3_m_valid_off", 64'(m_valid), 64'(0));
        chk("t3_s_ready_on",  64'(s_ready), 64'(1));
        chk("t3_busy_off",    64'(busy),    64'(0));
        chk("t3_m_data_kept", 64'(m_data),  64'(4'b1110));

        // 4: dropped config writes (same-cycle accept, during EVAL, bad slot)
        s_valid = 1'b1; s_data = 8'b0000_0110;
        cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_slot = 3'd2; cfg_idx = 3'd7;
        #1;
        chk("t4_cfg_ready_sv", 64'(cfg_ready), 64'(0));
        tick();
        s_valid = 1'b0;
        cfg_slot = 3'd1;
        tick();
        cfg_we = 1'b0;
        repeat (3) tick();
        chk("t4_m_data_a", 64'(m_data), 64'(4'b1110));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        cfg(0, 6, 7);
        run_vec(8'b0000_0110, "t4_readback", 4'b1110);

        // 5: reset mid-evaluation
        s_valid = 1'b1; s_data = 8'b0000_0110;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        chk("t5_sel2", 64'(lut_sel), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("t5_busy",    64'(busy),    64'(0));
        chk("t5_s_ready", 64'(s_ready), 64'(1));
        chk("t5_m_data",  64'(m_data),  64'(0));
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t5_no_m_valid", 64'(m_valid), 64'(0));
        end
        s_valid = 1'b1; s_data = 8'h01;
        tick();
        s_valid = 1'b0;
        chk("t5_lut_in_ones", 64'(lut_in), 64'(6'b111111));
        repeat (4) tick();
        chk("t5_m_valid", 64'(m_valid), 64'(1));
        chk("t5_m_data0", 64'(m_data),  64'(4'b0000));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;

        // 6: back-to-back vectors with s_valid held and m_ready=1
        cfg(2, 1, 1);
        cfg(2, 2, 2);
        s_valid = 1'b1; s_data = 8'h06; m_ready = 1'b1;
        first_acc = -1; second_acc = -1; n_acc = 0; n_hs = 0;
        for (int c = 0; c < 20; c++) begin
            acc = s_valid && s_ready;
            if (m_valid && m_ready) begin
                chk("t6_hs_data", 64'(m_data), (n_hs == 0) ? 64'(4'b1011) : 64'(4'b0100));
                n_hs++;
            end
            if (acc) begin
                if (n_acc == 0) first_acc = c;
                else            second_acc = c;
                n_acc++;
            end
            tick();
            if (acc && n_acc == 1) s_data  = 8'h05;
            if (acc && n_acc == 2) s_valid = 1'b0;
        end
        m_ready = 1'b0;
        chk("t6_accepts",    64'(n_acc), 64'(2));
        chk("t6_handshakes", 64'(n_hs),  64'(2));
        chk("t6_period",     64'(second_acc - first_acc), 64'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
